// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Sequencing controller for the 5-stage FloatSD4 MAC pipeline. Issues operand
//   groups into stage 1, drives the pipeline-wide inhibit, and keeps a tag shadow
//   of the pipeline so that only group-final results are handed downstream over a
//   valid/ready handshake. One job = i_num outputs of i_len MAC operations each.
//
//   Build option: define MAC_SEQ_CTRL_CHECK_EN to compare i_pipe_valid against the
//   tag shadow every cycle and raise a sticky o_err on mismatch. Without it the
//   compare logic is absent and o_err is tied low.
//
//   Ports
//     i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//     i_start             job start, sampled only in IDLE (with i_len, i_num)
//     i_len, i_num        MAC ops per output, outputs per job
//     i_op_avail          operand source has a pair ready
//     o_op_req            issue strobe (stage-1 valid, operand pop)
//     o_op_first/last     issued op is first/last of its group
//     o_inhibit           global pipeline stall
//     i_pipe_valid        final-stage valid from the pipeline
//     o_out_valid         group result presentable; i_out_ready accepts it
//     o_out_last          presented result is the last of the job
//     o_busy, o_done      not IDLE / one-cycle completion pulse
//     o_err               sticky tag/pipeline mismatch
//
//   state  | meaning
//   IDLE   | waiting for i_start
//   ISSUE  | issuing ops while operands are available and no stall
//   DRAIN  | all ops issued, waiting for the tag shadow to empty
//   DONE   | one-cycle completion pulse

module mac_seq_ctrl #(
    parameter int CNT_W = 10,
    parameter int DEPTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic [CNT_W-1:0] i_num,
    input  logic             i_op_avail,
    output logic             o_op_req,
    output logic             o_op_first,
    output logic             o_op_last,
    output logic             o_inhibit,
    input  logic             i_pipe_valid,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] grp_cnt_q, grp_cnt_d;
    logic [DEPTH-1:0] tag_vld_q, tag_vld_d;
    logic [DEPTH-1:0] tag_last_q, tag_last_d;
    logic [DEPTH-1:0] tag_jlast_q, tag_jlast_d;

    logic fire;
    logic op_last_hit;
    logic grp_last_hit;
    logic out_valid;
    logic inhibit;

    assign op_last_hit  = (op_cnt_q == (len_q - CNT_ONE));
    assign grp_last_hit = (grp_cnt_q == (num_q - CNT_ONE));

    // Only group-final results are presented; intermediate pipeline outputs fall
    // through without a handshake.
    assign out_valid = tag_vld_q[DEPTH-1] & tag_last_q[DEPTH-1];
    assign inhibit   = out_valid & ~i_out_ready;
    assign fire      = (state_q == ST_ISSUE) & i_op_avail & ~inhibit;

    assign o_op_req    = fire;
    assign o_op_first  = fire & (op_cnt_q == '0);
    assign o_op_last   = fire & op_last_hit;
    assign o_inhibit   = inhibit;
    assign o_out_valid = out_valid;
    assign o_out_last  = out_valid & tag_jlast_q[DEPTH-1];
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);

    // Tag shadow advances exactly when the pipeline does.
    always_comb begin
        tag_vld_d   = tag_vld_q;
        tag_last_d  = tag_last_q;
        tag_jlast_d = tag_jlast_q;
        if (!inhibit) begin
            tag_vld_d   = {tag_vld_q[DEPTH-2:0],   fire};
            tag_last_d  = {tag_last_q[DEPTH-2:0],  o_op_last};
            tag_jlast_d = {tag_jlast_q[DEPTH-2:0], o_op_last & grp_last_hit};
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        num_d     = num_q;
        op_cnt_d  = op_cnt_q;
        grp_cnt_d = grp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    len_d     = i_len;
                    num_d     = i_num;
                    op_cnt_d  = '0;
                    grp_cnt_d = '0;
                    // An empty job skips issuing; it passes through DRAIN (tags
                    // are already empty) so o_done lands two cycles after i_start.
                    if ((i_len == '0) || (i_num == '0)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (fire) begin
                    if (op_last_hit) begin
                        op_cnt_d  = '0;
                        grp_cnt_d = grp_cnt_q + CNT_ONE;
                        if (grp_last_hit) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        op_cnt_d = op_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // Looking at the next-state shadow lets DONE follow the cycle in
                // which the final tag leaves the last stage.
                if (tag_vld_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            op_cnt_q    <= '0;
            grp_cnt_q   <= '0;
            tag_vld_q   <= '0;
            tag_last_q  <= '0;
            tag_jlast_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            op_cnt_q    <= op_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_last_q  <= tag_last_d;
            tag_jlast_q <= tag_jlast_d;
        end
    end

`ifdef MAC_SEQ_CTRL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (i_pipe_valid ^ tag_vld_q[DEPTH-1]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_pipe_valid;
    assign unused_pipe_valid = i_pipe_valid;
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

    localparam int CNT_W = 10;
    localparam int DEPTH = 5;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic [CNT_W-1:0] i_num;
    logic             i_op_avail;
    logic             o_op_req;
    logic             o_op_first;
    logic             o_op_last;
    logic             o_inhibit;
    logic             i_pipe_valid;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_out_last;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    mac_seq_ctrl #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_num        (i_num),
        .i_op_avail   (i_op_avail),
        .o_op_req     (o_op_req),
        .o_op_first   (o_op_first),
        .o_op_last    (o_op_last),
        .o_inhibit    (o_inhibit),
        .i_pipe_valid (i_pipe_valid),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_last   (o_out_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    typedef struct {
        int         cyc;
        logic [1:0] fl;
    } ev_t;

    ev_t op_q[$];
    ev_t out_q[$];
    ev_t done_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int job_s       = 0;
    int stall_lo    = 0;
    int stall_hi    = -1;
    int inh_cnt     = 0;
    bit avail_mode  = 0;
    bit pv_force    = 0;

    // Stand-in for the real MAC pipeline valid path.
    logic [DEPTH-1:0] pipe;
    logic             req_s, inh_s;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        req_s <= o_op_req;
        inh_s <= o_inhibit;
    end

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) pipe <= '0;
        else if (!inh_s) pipe <= {pipe[DEPTH-2:0], req_s};
    end

    assign i_pipe_valid = pipe[DEPTH-1] | pv_force;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event at cycle %0d with nothing expected", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    initial begin
        ev_t e;
        forever begin
            @(negedge i_clk);
            if (o_inhibit) inh_cnt++;
            if (o_op_req) begin
                if (op_q.size() == 0) unexpected("op_req");
                else begin
                    e = op_q.pop_front();
                    chk("op_cycle", cyc, e.cyc);
                    chk("op_first_last", int'({o_op_first, o_op_last}), int'(e.fl));
                end
            end
            if (o_out_valid && i_out_ready) begin
                if (out_q.size() == 0) unexpected("out_valid");
                else begin
                    e = out_q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("out_last", int'(o_out_last), int'(e.fl[0]));
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push_op(input int c, input bit first, input bit last);
        op_q.push_back('{cyc: c, fl: {first, last}});
    endtask

    task automatic push_out(input int c, input bit last);
        out_q.push_back('{cyc: c, fl: {1'b0, last}});
    endtask

    task automatic push_done(input int c);
        done_q.push_back('{cyc: c, fl: 2'b00});
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        i_op_avail  = avail_mode ? (((cyc - job_s) % 2) == 1) : 1'b1;
        i_out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Leaves the bench in cycle job_s+1, with i_start pulsed in cycle job_s.
    task automatic start_job(input int len, input int num);
        job_s = cyc + 1;
        step();
        i_start = 1'b1;
        i_len   = CNT_W'(len);
        i_num   = CNT_W'(num);
        step();
        i_start = 1'b0;
    endtask

    task automatic check_drained(input string name);
        chk({name, "_queues_empty"}, op_q.size() + out_q.size() + done_q.size(), 0);
        op_q.delete();
        out_q.delete();
        done_q.delete();
    endtask

    // len=3, num=2, no stalls: fires s+1..s+6, results at s+8 and s+11.
    task automatic basic_job(input string name);
        int s;
        s = cyc + 1;
        for (int i = 0; i < 6; i++) push_op(s + 1 + i, (i % 3) == 0, (i % 3) == 2);
        push_out(s + 8, 1'b0);
        push_out(s + 11, 1'b1);
        push_done(s + 12);
        inh_cnt = 0;
        start_job(3, 2);
        steps(14);
        chk({name, "_inhibit_cycles"}, inh_cnt, 0);
        check_drained(name);
    endtask

    initial begin
        int s;
        int offs[9];
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_len       = '0;
        i_num       = '0;
        i_op_avail  = 1'b1;
        i_out_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_outputs",
            int'({o_op_req, o_op_first, o_op_last, o_inhibit, o_out_valid,
                  o_out_last, o_busy, o_done, o_err}), 0);
        i_rst = 1'b0;
        steps(2);

        basic_job("basic");

        // Backpressure: len=3, num=3, ready low for 4 cycles at the first result.
        s = cyc + 1;
        offs = '{1, 2, 3, 4, 5, 6, 7, 12, 13};
        for (int i = 0; i < 9; i++) push_op(s + offs[i], (i % 3) == 0, (i % 3) == 2);
        push_out(s + 12, 1'b0);
        push_out(s + 15, 1'b0);
        push_out(s + 18, 1'b1);
        push_done(s + 19);
        stall_lo = s + 8;
        stall_hi = s + 11;
        inh_cnt  = 0;
        start_job(3, 3);
        steps(20);
        chk("bp_inhibit_cycles", inh_cnt, 4);
        check_drained("bp");
        stall_lo = 0;
        stall_hi = -1;

        // Operand gaps: len=4, num=1, avail on alternate cycles.
        s = cyc + 1;
        avail_mode = 1'b1;
        push_op(s + 1, 1'b1, 1'b0);
        push_op(s + 3, 1'b0, 1'b0);
        push_op(s + 5, 1'b0, 1'b0);
        push_op(s + 7, 1'b0, 1'b1);
        push_out(s + 12, 1'b1);
        push_done(s + 13);
        start_job(4, 1);
        steps(15);
        check_drained("gaps");
        avail_mode = 1'b0;

        // Zero length: no ops, busy for two cycles, done two cycles after start.
        s = cyc + 1;
        push_done(s + 2);
        start_job(0, 5);
        chk("zero_busy_1", int'(o_busy), 1);
        step();
        chk("zero_busy_2", int'(o_busy), 1);
        step();
        chk("zero_busy_3", int'(o_busy), 0);
        steps(3);
        check_drained("zero");

        // Reset mid-job with three ops in flight.
        s = cyc + 1;
        push_op(s + 1, 1'b1, 1'b0);
        push_op(s + 2, 1'b0, 1'b0);
        push_op(s + 3, 1'b0, 1'b1);
        start_job(3, 2);
        steps(3);
        #1;
        i_rst = 1'b1;
        #1;
        chk("midjob_reset_outputs",
            int'({o_op_req, o_op_first, o_op_last, o_inhibit, o_out_valid,
                  o_out_last, o_busy, o_done, o_err}), 0);
        step();
        i_rst = 1'b0;
        steps(2);
        check_drained("midjob");
        basic_job("after_reset");

`ifdef MAC_SEQ_CTRL_CHECK_EN
        step();
        pv_force = 1'b1;
        chk("err_before", int'(o_err), 0);
        step();
        pv_force = 1'b0;
        chk("err_set", int'(o_err), 1);
        basic_job("err_traffic");
        chk("err_sticky", int'(o_err), 1);
        i_rst = 1'b1;
        #1;
        chk("err_cleared", int'(o_err), 0);
        step();
        i_rst = 1'b0;
        steps(2);
`endif
        chk("err_final", int'(o_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
